// File: rtl/cnn_layer_accel_job_dispatch.sv
// Queues layer-job descriptors and issues them to C_NUM_QUADS quads over the start/complete handshake.
// Optional per-quad watchdog is enabled by defining CNL_JOB_DISPATCH_TIMEOUT_EN.
module cnn_layer_accel_job_dispatch #(
  parameter int unsigned C_NUM_QUADS       = 4,
  parameter int unsigned C_JOB_FIFO_DEPTH  = 8,
  parameter int unsigned C_JOB_PARAM_WIDTH = 128,
  parameter int unsigned C_TIMEOUT_CYCLES  = 65536,
  localparam int unsigned QW = (C_NUM_QUADS > 1) ? $clog2(C_NUM_QUADS) : 1,
  localparam int unsigned OW = $clog2(C_JOB_FIFO_DEPTH + C_NUM_QUADS + 1)
) (
  input  logic                         clk_if,
  input  logic                         rst,
  input  logic                         job_in_valid,
  output logic                         job_in_ready,
  input  logic [C_JOB_PARAM_WIDTH-1:0] job_in_params,
  input  logic                         job_in_any,
  input  logic [QW-1:0]                job_in_quad_id,
  output logic [C_NUM_QUADS-1:0]       job_start,
  input  logic [C_NUM_QUADS-1:0]       job_accept,
  output logic [C_JOB_PARAM_WIDTH-1:0] job_parameters,
  input  logic [C_NUM_QUADS-1:0]       job_complete,
  output logic [C_NUM_QUADS-1:0]       job_complete_ack,
  output logic                         done_valid,
  output logic [QW-1:0]                done_quad_id,
  output logic [OW-1:0]                outstanding
`ifdef CNL_JOB_DISPATCH_TIMEOUT_EN
  ,
  output logic [C_NUM_QUADS-1:0]       timeout_err
`endif
);

  localparam int unsigned AW = (C_JOB_FIFO_DEPTH > 1) ? $clog2(C_JOB_FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(C_JOB_FIFO_DEPTH + 1);

  typedef struct packed {
    logic [C_JOB_PARAM_WIDTH-1:0] params;
    logic                         any;
    logic [QW-1:0]                quad_id;
  } job_t;

  typedef enum logic [1:0] {StIdle, StStart, StBusy, StAck} state_e;

  job_t                         mem [C_JOB_FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]                count_q, count_d;
  logic                         ready_q;
  state_e                       state_q [C_NUM_QUADS];
  logic [QW-1:0]                rr_ptr_q;
  logic [C_NUM_QUADS-1:0]       start_q, ack_q;
  logic [C_JOB_PARAM_WIDTH-1:0] params_q;
  logic                         done_valid_q;
  logic [QW-1:0]                done_id_q;
  logic [OW-1:0]                outstanding_q;

  job_t                         head;
  logic                         head_any, start_pending, any_found;
  logic                         dispatch, push, pop, retire;
  logic [QW-1:0]                any_idx, disp_idx, ret_idx;
  logic [C_NUM_QUADS-1:0]       hit;

`ifdef CNL_JOB_DISPATCH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(C_TIMEOUT_CYCLES + 1);
  logic [TW-1:0]                tcnt_q [C_NUM_QUADS];
  logic [C_NUM_QUADS-1:0]       terr_q;
  assign timeout_err = terr_q;
`endif

  always_comb begin
    int unsigned k;
    k   = 0;
    hit = '0;
`ifdef CNL_JOB_DISPATCH_TIMEOUT_EN
    for (int unsigned q = 0; q < C_NUM_QUADS; q++) begin
      hit[q] = (tcnt_q[q] >= TW'(C_TIMEOUT_CYCLES - 1));
    end
`endif
    head = mem[rd_ptr_q];
    // Out-of-range targets fall back to any-quad placement
    head_any = head.any || (32'(head.quad_id) >= C_NUM_QUADS);

    start_pending = 1'b0;
    for (int unsigned q = 0; q < C_NUM_QUADS; q++) begin
      if (state_q[q] == StStart) start_pending = 1'b1;
    end

    any_found = 1'b0;
    any_idx   = '0;
    for (int unsigned i = 0; i < C_NUM_QUADS; i++) begin
      k = (32'(rr_ptr_q) + i) % C_NUM_QUADS;
      if (!any_found && state_q[QW'(k)] == StIdle) begin
        any_found = 1'b1;
        any_idx   = QW'(k);
      end
    end

    disp_idx = head_any ? any_idx : head.quad_id;
    dispatch = (count_q != '0) && !start_pending &&
               (head_any ? any_found : (state_q[head.quad_id] == StIdle));
    push     = job_in_valid && ready_q;
    pop      = dispatch;
    count_d  = count_q + CW'(push) - CW'(pop);

    // Lowest-index busy quad with a pending completion retires first
    retire  = 1'b0;
    ret_idx = '0;
    for (int unsigned q = 0; q < C_NUM_QUADS; q++) begin
      if (!retire && state_q[q] == StBusy && (job_complete[q] || hit[q])) begin
        retire  = 1'b1;
        ret_idx = QW'(q);
      end
    end
  end

  always_ff @(posedge clk_if) begin
    if (push) mem[wr_ptr_q] <= {job_in_params, job_in_any, job_in_quad_id};
  end

  always_ff @(posedge clk_if) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ready_q       <= 1'b1;
      rr_ptr_q      <= '0;
      start_q       <= '0;
      ack_q         <= '0;
      params_q      <= '0;
      done_valid_q  <= 1'b0;
      done_id_q     <= '0;
      outstanding_q <= '0;
      for (int unsigned q = 0; q < C_NUM_QUADS; q++) begin
        state_q[q] <= StIdle;
      end
`ifdef CNL_JOB_DISPATCH_TIMEOUT_EN
      terr_q <= '0;
      for (int unsigned q = 0; q < C_NUM_QUADS; q++) begin
        tcnt_q[q] <= '0;
      end
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q       <= count_d;
      // Registered full flag: a same-cycle pop does not open a slot until next cycle
      ready_q       <= (count_d != CW'(C_JOB_FIFO_DEPTH));
      outstanding_q <= outstanding_q + OW'(push) - OW'(done_valid_q);

      if (dispatch) begin
        params_q <= head.params;
        if (head_any) begin
          rr_ptr_q <= (32'(disp_idx) + 1 == C_NUM_QUADS) ? '0 : disp_idx + QW'(1);
        end
      end

      ack_q        <= '0;
      done_valid_q <= retire;
      if (retire) done_id_q <= ret_idx;

      for (int unsigned q = 0; q < C_NUM_QUADS; q++) begin
        case (state_q[q])
          StIdle: begin
            if (dispatch && disp_idx == QW'(q)) begin
              state_q[q] <= StStart;
              start_q[q] <= 1'b1;
            end
          end
          StStart: begin
            if (job_accept[q]) begin
              state_q[q] <= StBusy;
              start_q[q] <= 1'b0;
`ifdef CNL_JOB_DISPATCH_TIMEOUT_EN
              tcnt_q[q]  <= '0;
`endif
            end
          end
          StBusy: begin
            if (retire && ret_idx == QW'(q)) begin
              state_q[q] <= StAck;
              ack_q[q]   <= 1'b1;
`ifdef CNL_JOB_DISPATCH_TIMEOUT_EN
              if (hit[q]) terr_q[q] <= 1'b1;
`endif
            end
`ifdef CNL_JOB_DISPATCH_TIMEOUT_EN
            else if (!hit[q]) begin
              tcnt_q[q] <= tcnt_q[q] + TW'(1);
            end
`endif
          end
          StAck:   state_q[q] <= StIdle;
          default: state_q[q] <= StIdle;
        endcase
      end
    end
  end

  assign job_in_ready     = ready_q;
  assign job_start        = start_q;
  assign job_parameters   = params_q;
  assign job_complete_ack = ack_q;
  assign done_valid       = done_valid_q;
  assign done_quad_id     = done_id_q;
  assign outstanding      = outstanding_q;

endmodule

// File: tb/tb_cnn_layer_accel_job_dispatch.sv
// Directed bench for cnn_layer_accel_job_dispatch: cycle table plus hand-written corner sequences.
// Watchdog sequence is compiled only with CNL_JOB_DISPATCH_TIMEOUT_EN.
module tb_cnn_layer_accel_job_dispatch;

  localparam int unsigned NQ = 4;
  localparam int unsigned PW = 32;
  localparam int unsigned NV = 23;

  logic          clk_if = 1'b0;
  logic          rst;
  logic          job_in_valid;
  logic          job_in_ready;
  logic [PW-1:0] job_in_params;
  logic          job_in_any;
  logic [1:0]    job_in_quad_id;
  logic [NQ-1:0] job_start;
  logic [NQ-1:0] job_accept;
  logic [PW-1:0] job_parameters;
  logic [NQ-1:0] job_complete;
  logic [NQ-1:0] job_complete_ack;
  logic          done_valid;
  logic [1:0]    done_quad_id;
  logic [3:0]    outstanding;
`ifdef CNL_JOB_DISPATCH_TIMEOUT_EN
  logic [NQ-1:0] timeout_err;
`endif

  cnn_layer_accel_job_dispatch #(
    .C_NUM_QUADS      (NQ),
    .C_JOB_FIFO_DEPTH (8),
    .C_JOB_PARAM_WIDTH(PW),
    .C_TIMEOUT_CYCLES (16)
  ) dut (
    .clk_if          (clk_if),
    .rst             (rst),
    .job_in_valid    (job_in_valid),
    .job_in_ready    (job_in_ready),
    .job_in_params   (job_in_params),
    .job_in_any      (job_in_any),
    .job_in_quad_id  (job_in_quad_id),
    .job_start       (job_start),
    .job_accept      (job_accept),
    .job_parameters  (job_parameters),
    .job_complete    (job_complete),
    .job_complete_ack(job_complete_ack),
    .done_valid      (done_valid),
    .done_quad_id    (done_quad_id),
    .outstanding     (outstanding)
`ifdef CNL_JOB_DISPATCH_TIMEOUT_EN
    ,
    .timeout_err     (timeout_err)
`endif
  );

  always #5 clk_if = ~clk_if;

  typedef struct {
    logic          valid;
    logic [PW-1:0] params;
    logic          any;
    logic [1:0]    qid;
    logic [3:0]    accept;
    logic [3:0]    complete;
    logic          exp_ready;
    logic [3:0]    exp_start;
    logic [PW-1:0] exp_params;
    logic [3:0]    exp_ack;
    logic          exp_dv;
    logic [1:0]    exp_id;
    logic [3:0]    exp_out;
  } vec_t;

  vec_t vecs [NV];
  int   checks = 0;
  int   failures = 0;

  task automatic step();
    @(posedge clk_if);
    #1;
  endtask

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    // Four any-jobs fill quads 0..3, then completions, then a targeted job blocking the queue
    vecs[0]  = '{1'b1, 32'hA0, 1'b1, 2'd0, 4'h0, 4'h0, 1'b1, 4'h0, 32'h00, 4'h0, 1'b0, 2'd0, 4'd1};
    vecs[1]  = '{1'b1, 32'hA1, 1'b1, 2'd0, 4'h0, 4'h0, 1'b1, 4'h1, 32'hA0, 4'h0, 1'b0, 2'd0, 4'd2};
    vecs[2]  = '{1'b1, 32'hA2, 1'b1, 2'd0, 4'h1, 4'h0, 1'b1, 4'h0, 32'hA0, 4'h0, 1'b0, 2'd0, 4'd3};
    vecs[3]  = '{1'b1, 32'hA3, 1'b1, 2'd0, 4'h0, 4'h0, 1'b1, 4'h2, 32'hA1, 4'h0, 1'b0, 2'd0, 4'd4};
    vecs[4]  = '{1'b0, 32'h00, 1'b0, 2'd0, 4'h2, 4'h0, 1'b1, 4'h0, 32'hA1, 4'h0, 1'b0, 2'd0, 4'd4};
    vecs[5]  = '{1'b0, 32'h00, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 4'h4, 32'hA2, 4'h0, 1'b0, 2'd0, 4'd4};
    vecs[6]  = '{1'b0, 32'h00, 1'b0, 2'd0, 4'h4, 4'h0, 1'b1, 4'h0, 32'hA2, 4'h0, 1'b0, 2'd0, 4'd4};
    vecs[7]  = '{1'b0, 32'h00, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 4'h8, 32'hA3, 4'h0, 1'b0, 2'd0, 4'd4};
    vecs[8]  = '{1'b0, 32'h00, 1'b0, 2'd0, 4'h8, 4'h0, 1'b1, 4'h0, 32'hA3, 4'h0, 1'b0, 2'd0, 4'd4};
    vecs[9]  = '{1'b0, 32'h00, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 4'h0, 32'hA3, 4'h0, 1'b0, 2'd0, 4'd4};
    vecs[10] = '{1'b0, 32'h00, 1'b0, 2'd0, 4'h0, 4'hA, 1'b1, 4'h0, 32'hA3, 4'h2, 1'b1, 2'd1, 4'd4};
    vecs[11] = '{1'b0, 32'h00, 1'b0, 2'd0, 4'h0, 4'h8, 1'b1, 4'h0, 32'hA3, 4'h8, 1'b1, 2'd3, 4'd3};
    vecs[12] = '{1'b0, 32'h00, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 4'h0, 32'hA3, 4'h0, 1'b0, 2'd3, 4'd2};
    vecs[13] = '{1'b0, 32'h00, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 4'h0, 32'hA3, 4'h0, 1'b0, 2'd3, 4'd2};
    vecs[14] = '{1'b1, 32'hB2, 1'b0, 2'd2, 4'h0, 4'h0, 1'b1, 4'h0, 32'hA3, 4'h0, 1'b0, 2'd3, 4'd3};
    vecs[15] = '{1'b1, 32'hB0, 1'b1, 2'd0, 4'h0, 4'h0, 1'b1, 4'h0, 32'hA3, 4'h0, 1'b0, 2'd3, 4'd4};
    vecs[16] = '{1'b0, 32'h00, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 4'h0, 32'hA3, 4'h0, 1'b0, 2'd3, 4'd4};
    vecs[17] = '{1'b0, 32'h00, 1'b0, 2'd0, 4'h0, 4'h4, 1'b1, 4'h0, 32'hA3, 4'h4, 1'b1, 2'd2, 4'd4};
    vecs[18] = '{1'b0, 32'h00, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 4'h0, 32'hA3, 4'h0, 1'b0, 2'd2, 4'd3};
    vecs[19] = '{1'b0, 32'h00, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 4'h4, 32'hB2, 4'h0, 1'b0, 2'd2, 4'd3};
    vecs[20] = '{1'b0, 32'h00, 1'b0, 2'd0, 4'h4, 4'h0, 1'b1, 4'h0, 32'hB2, 4'h0, 1'b0, 2'd2, 4'd3};
    vecs[21] = '{1'b0, 32'h00, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 4'h2, 32'hB0, 4'h0, 1'b0, 2'd2, 4'd3};
    vecs[22] = '{1'b0, 32'h00, 1'b0, 2'd0, 4'h2, 4'h0, 1'b1, 4'h0, 32'hB0, 4'h0, 1'b0, 2'd2, 4'd3};

    rst            = 1'b1;
    job_in_valid   = 1'b0;
    job_in_params  = '0;
    job_in_any     = 1'b0;
    job_in_quad_id = '0;
    job_accept     = '0;
    job_complete   = '0;
    step();
    step();
    check("rst_ready",  48'(job_in_ready),     48'(1));
    check("rst_start",  48'(job_start),        48'(0));
    check("rst_params", 48'(job_parameters),   48'(0));
    check("rst_ack",    48'(job_complete_ack), 48'(0));
    check("rst_done",   48'({done_valid, done_quad_id}), 48'(0));
    check("rst_out",    48'(outstanding),      48'(0));
`ifdef CNL_JOB_DISPATCH_TIMEOUT_EN
    check("rst_terr",   48'(timeout_err),      48'(0));
`endif
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      job_in_valid   = vecs[i].valid;
      job_in_params  = vecs[i].params;
      job_in_any     = vecs[i].any;
      job_in_quad_id = vecs[i].qid;
      job_accept     = vecs[i].accept;
      job_complete   = vecs[i].complete;
      step();
      check($sformatf("vec%0d", i),
            {job_in_ready, job_start, job_parameters, job_complete_ack,
             done_valid, done_quad_id, outstanding},
            {vecs[i].exp_ready, vecs[i].exp_start, vecs[i].exp_params, vecs[i].exp_ack,
             vecs[i].exp_dv, vecs[i].exp_id, vecs[i].exp_out});
    end
    job_in_valid = 1'b0;
    job_accept   = '0;
    job_complete = '0;

    // Full FIFO: quad 0 parked in START blocks dispatch while 8 more jobs queue up
    rst = 1'b1;
    step();
    rst           = 1'b0;
    job_in_valid  = 1'b1;
    job_in_any    = 1'b1;
    job_in_params = 32'hC00;
    step();
    for (int i = 0; i < 8; i++) begin
      job_in_params = 32'hD0 + 32'(i);
      step();
    end
    check("full_ready", 48'(job_in_ready), 48'(0));
    check("full_start", 48'(job_start),    48'(1));
    check("full_out",   48'(outstanding),  48'(9));
    job_in_params = 32'hD8;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("held_ready%0d", i), 48'(job_in_ready), 48'(0));
    end
    check("held_out", 48'(outstanding), 48'(9));
    job_accept = 4'h1;
    step();
    job_accept = 4'h0;
    check("accept_ready", 48'(job_in_ready), 48'(0));
    step();
    check("pop_start",  48'(job_start),      48'(2));
    check("pop_params", 48'(job_parameters), 48'(32'hD0));
    check("pop_ready",  48'(job_in_ready),   48'(1));
    step();
    job_in_valid = 1'b0;
    check("ninth_out",   48'(outstanding),  48'(10));
    check("ninth_ready", 48'(job_in_ready), 48'(0));

    // Reset while quad 0 is in START with three jobs queued
    rst = 1'b1;
    step();
    rst          = 1'b0;
    job_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      job_in_params = 32'hE0 + 32'(i);
      step();
    end
    job_in_valid = 1'b0;
    check("mid_start", 48'(job_start),   48'(1));
    check("mid_out",   48'(outstanding), 48'(4));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_start",  48'(job_start),      48'(0));
    check("mid_rst_out",    48'(outstanding),    48'(0));
    check("mid_rst_ready",  48'(job_in_ready),   48'(1));
    check("mid_rst_params", 48'(job_parameters), 48'(0));

    // Quad 0 accepts and never completes
    job_in_valid  = 1'b1;
    job_in_params = 32'hF0;
    step();
    job_in_valid = 1'b0;
    step();
    check("wd_start", 48'(job_start), 48'(1));
    job_accept = 4'h1;
    step();
    job_accept = 4'h0;
    repeat (15) step();
`ifdef CNL_JOB_DISPATCH_TIMEOUT_EN
    check("wd_pre_terr", 48'(timeout_err), 48'(0));
    check("wd_pre_done", 48'(done_valid),  48'(0));
    step();
    check("wd_terr", 48'(timeout_err),                 48'(1));
    check("wd_done", 48'({done_valid, done_quad_id}),  48'({1'b1, 2'd0}));
    check("wd_ack",  48'(job_complete_ack),            48'(1));
    step();
    check("wd_sticky", 48'(timeout_err), 48'(1));
    check("wd_single", 48'(done_valid),  48'(0));
`else
    repeat (5) step();
    check("nowd_done", 48'(done_valid),  48'(0));
    check("nowd_out",  48'(outstanding), 48'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
